// File: rtl/gram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gram_pkg
// Brief    : Shared constants, ASCII codes, state encodings and address helper
//            for the 80x30 text console writer and its cursor sub-module.
// Revision : 1.0 - initial release
// ============================================================================
package gram_pkg;

  // Screen geometry and text RAM shape
  localparam int CHAR_COUNT_COLUMN = 80;
  localparam int CHAR_COUNT_ROW    = 30;
  localparam int GRAM_DEPTH        = CHAR_COUNT_COLUMN * CHAR_COUNT_ROW;
  localparam int GRAM_ADDR_WIDTH   = 12;
  localparam int GRAM_DATA_WIDTH   = 7;

  // Cursor counter widths
  localparam int COL_WIDTH = 7;
  localparam int ROW_WIDTH = 5;

  // Sized terminal values so comparisons stay width-matched
  localparam logic [COL_WIDTH-1:0]       COL_LAST  = COL_WIDTH'(CHAR_COUNT_COLUMN - 1);
  localparam logic [ROW_WIDTH-1:0]       ROW_LAST  = ROW_WIDTH'(CHAR_COUNT_ROW - 1);
  localparam logic [COL_WIDTH-1:0]       LINE_LEN  = COL_WIDTH'(CHAR_COUNT_COLUMN);
  localparam logic [GRAM_ADDR_WIDTH-1:0] CLEAR_END = GRAM_ADDR_WIDTH'(GRAM_DEPTH);

  // ASCII codes with special meaning to the console
  localparam logic [GRAM_DATA_WIDTH-1:0] SPACE = 7'h20;
  localparam logic [GRAM_DATA_WIDTH-1:0] LF    = 7'h0A;
  localparam logic [GRAM_DATA_WIDTH-1:0] CR    = 7'h0D;
  localparam logic [GRAM_DATA_WIDTH-1:0] BS    = 7'h08;
  localparam logic [GRAM_DATA_WIDTH-1:0] FF    = 7'h0C;
  localparam logic [GRAM_DATA_WIDTH-1:0] TILDE = 7'h7E;

  // Writer state machine
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WRITE      = 2'd1,
    ST_CLEAR_LINE = 2'd2,
    ST_CLEAR_ALL  = 2'd3
  } console_state_t;

  // Cursor movement commands issued by the writer
  typedef enum logic [2:0] {
    CUR_NONE    = 3'd0,
    CUR_ADVANCE = 3'd1,
    CUR_NEWLINE = 3'd2,
    CUR_RETURN  = 3'd3,
    CUR_BACK    = 3'd4,
    CUR_HOME    = 3'd5
  } cursor_cmd_t;

  // Codes 0x20..0x7E are drawn; everything else is control or ignored
  function automatic logic is_printable(input logic [GRAM_DATA_WIDTH-1:0] code);
    return (code >= SPACE) && (code <= TILDE);
  endfunction

  // row*80 + col as row*64 + row*16 + col; max 29*80+79 = 2399 fits 12 bits
  function automatic logic [GRAM_ADDR_WIDTH-1:0] cell_address(
    input logic [ROW_WIDTH-1:0] row,
    input logic [COL_WIDTH-1:0] col
  );
    return {1'b0, row, 6'b0} + {3'b0, row, 4'b0} + {5'b0, col};
  endfunction

endpackage
`default_nettype wire

// File: rtl/text_console_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : text_console_writer_if
// Brief    : Character input handshake, clear request, text RAM write port and
//            status signals of the console writer, bundled for port passing.
// Revision : 1.0 - initial release
// ============================================================================
interface text_console_writer_if;
  import gram_pkg::*;

  logic                       char_valid;
  logic [GRAM_DATA_WIDTH-1:0] char_data;
  logic                       char_ready;
  logic                       clear_req;
  logic                       gram_write_enable;
  logic [GRAM_ADDR_WIDTH-1:0] gram_write_address;
  logic [GRAM_DATA_WIDTH-1:0] gram_write_data;
  logic [COL_WIDTH-1:0]       cursor_col;
  logic [ROW_WIDTH-1:0]       cursor_row;
  logic                       busy;

  // Character source / RAM observer side
  modport master (
    output char_valid, char_data, clear_req,
    input  char_ready, gram_write_enable, gram_write_address, gram_write_data,
    input  cursor_col, cursor_row, busy
  );

  // Console writer side
  modport slave (
    input  char_valid, char_data, clear_req,
    output char_ready, gram_write_enable, gram_write_address, gram_write_data,
    output cursor_col, cursor_row, busy
  );

endinterface
`default_nettype wire

// File: rtl/console_cursor.sv
`default_nettype none
// ============================================================================
// Module   : console_cursor
// Brief    : Column/row cursor counters with line wrap and screen wrap, plus
//            text RAM address generation for the cursor cell and for a cell
//            on the cursor row selected by the line-clear counter.
// Revision : 1.0 - initial release
// ============================================================================
module console_cursor
  import gram_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  cursor_cmd_t                cmd,
  input  logic [COL_WIDTH-1:0]       line_col,
  output logic [COL_WIDTH-1:0]       col,
  output logic [ROW_WIDTH-1:0]       row,
  output logic                       at_eol,
  output logic [GRAM_ADDR_WIDTH-1:0] cell_addr,
  output logic [GRAM_ADDR_WIDTH-1:0] line_addr
);

  logic [COL_WIDTH-1:0] col_d, col_q;
  logic [ROW_WIDTH-1:0] row_d, row_q;
  logic [ROW_WIDTH-1:0] row_next;

  // Next cursor position for the requested movement
  always_comb begin
    row_next = (row_q == ROW_LAST) ? '0 : row_q + ROW_WIDTH'(1);
    col_d    = col_q;
    row_d    = row_q;
    unique case (cmd)
      CUR_ADVANCE: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_next;
        end else begin
          col_d = col_q + COL_WIDTH'(1);
        end
      end
      CUR_NEWLINE: begin
        col_d = '0;
        row_d = row_next;
      end
      CUR_RETURN: col_d = '0;
      CUR_BACK: begin
        if (col_q != '0) begin
          col_d = col_q - COL_WIDTH'(1);
        end
      end
      CUR_HOME: begin
        col_d = '0;
        row_d = '0;
      end
      default: begin
        col_d = col_q;
        row_d = row_q;
      end
    endcase
  end

  // Cursor registers, homed on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col       = col_q;
  assign row       = row_q;
  assign at_eol    = (col_q == COL_LAST);
  assign cell_addr = cell_address(row_q, col_q);
  assign line_addr = cell_address(row_q, line_col);

endmodule
`default_nettype wire

// File: rtl/text_console_writer.sv
`default_nettype none
// ============================================================================
// Module   : text_console_writer
// Brief    : Streams ASCII characters into an 80x30 text RAM. Handles printable
//            writes, LF/CR/BS/FF control codes, automatic line clear on a row
//            advance and a full-screen clear after reset or on request.
// Revision : 1.0 - initial release
// ============================================================================
module text_console_writer
  import gram_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  text_console_writer_if.slave bus
);

  console_state_t             state_d, state_q;
  logic [GRAM_ADDR_WIDTH-1:0] clr_cnt_d, clr_cnt_q;
  logic [COL_WIDTH-1:0]       line_cnt_d, line_cnt_q;
  logic                       pending_d, pending_q;
  logic                       wrap_d, wrap_q;
  logic                       we_d, we_q;
  logic [GRAM_ADDR_WIDTH-1:0] addr_d, addr_q;
  logic [GRAM_DATA_WIDTH-1:0] data_d, data_q;
  logic                       ready_d, ready_q;
  logic                       busy_d, busy_q;

  logic                       start_clear;
  cursor_cmd_t                cur_cmd;
  logic [COL_WIDTH-1:0]       line_col;
  logic [COL_WIDTH-1:0]       cur_col;
  logic [ROW_WIDTH-1:0]       cur_row;
  logic                       cur_at_eol;
  logic [GRAM_ADDR_WIDTH-1:0] cur_cell_addr;
  logic [GRAM_ADDR_WIDTH-1:0] cur_line_addr;

  // The line clear walks the cursor row; column 0 is emitted on leaving WRITE
  assign line_col = (state_q == ST_CLEAR_LINE) ? line_cnt_q : '0;

  console_cursor u_cursor (
    .clk       (clk),
    .rst       (rst),
    .cmd       (cur_cmd),
    .line_col  (line_col),
    .col       (cur_col),
    .row       (cur_row),
    .at_eol    (cur_at_eol),
    .cell_addr (cur_cell_addr),
    .line_addr (cur_line_addr)
  );

  // Next state and next registered outputs; each state's outputs describe
  // the RAM write happening while that state is visible
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    line_cnt_d  = line_cnt_q;
    pending_d   = pending_q | bus.clear_req;
    wrap_d      = wrap_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    cur_cmd     = CUR_NONE;
    start_clear = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A clear beats a character offered in the same cycle; the clear
        // would erase that character anyway
        if (pending_q || bus.clear_req) begin
          start_clear = 1'b1;
        end else if (bus.char_valid && ready_q) begin
          if (bus.char_data == FF) begin
            start_clear = 1'b1;
          end else begin
            state_d = ST_WRITE;
            wrap_d  = 1'b0;
            if (is_printable(bus.char_data)) begin
              we_d    = 1'b1;
              addr_d  = cur_cell_addr;
              data_d  = bus.char_data;
              cur_cmd = CUR_ADVANCE;
              wrap_d  = cur_at_eol;
            end else if (bus.char_data == LF) begin
              cur_cmd = CUR_NEWLINE;
              wrap_d  = 1'b1;
            end else if (bus.char_data == CR) begin
              cur_cmd = CUR_RETURN;
            end else if (bus.char_data == BS) begin
              cur_cmd = CUR_BACK;
            end
          end
        end
      end

      ST_WRITE: begin
        // The cursor already sits on the new row, so blank it from column 0
        if (wrap_q) begin
          state_d    = ST_CLEAR_LINE;
          we_d       = 1'b1;
          addr_d     = cur_line_addr;
          data_d     = SPACE;
          line_cnt_d = COL_WIDTH'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CLEAR_LINE: begin
        if (line_cnt_q == LINE_LEN) begin
          state_d = ST_IDLE;
        end else begin
          we_d       = 1'b1;
          addr_d     = cur_line_addr;
          data_d     = SPACE;
          line_cnt_d = line_cnt_q + COL_WIDTH'(1);
        end
      end

      ST_CLEAR_ALL: begin
        if (clr_cnt_q == CLEAR_END) begin
          state_d = ST_IDLE;
        end else begin
          we_d      = 1'b1;
          addr_d    = clr_cnt_q;
          data_d    = SPACE;
          clr_cnt_d = clr_cnt_q + GRAM_ADDR_WIDTH'(1);
        end
      end

      default: state_d = ST_CLEAR_ALL;
    endcase

    // Entering the full clear emits address 0 immediately and collapses any
    // requests that arrived so far
    if (start_clear) begin
      state_d   = ST_CLEAR_ALL;
      pending_d = 1'b0;
      we_d      = 1'b1;
      addr_d    = '0;
      data_d    = SPACE;
      clr_cnt_d = GRAM_ADDR_WIDTH'(1);
      cur_cmd   = CUR_HOME;
    end
  end

  // Status outputs follow the next state; a waiting clear keeps ready low
  always_comb begin
    ready_d = (state_d == ST_IDLE) && !pending_d;
    busy_d  = (state_d != ST_IDLE);
  end

  // State and registered outputs; reset restarts the full-screen clear
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_CLEAR_ALL;
      clr_cnt_q  <= '0;
      line_cnt_q <= '0;
      pending_q  <= 1'b0;
      wrap_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= SPACE;
      ready_q    <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      line_cnt_q <= line_cnt_d;
      pending_q  <= pending_d;
      wrap_q     <= wrap_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.char_ready         = ready_q;
  assign bus.busy               = busy_q;
  assign bus.gram_write_enable  = we_q;
  assign bus.gram_write_address = addr_q;
  assign bus.gram_write_data    = data_q;
  assign bus.cursor_col         = cur_col;
  assign bus.cursor_row         = cur_row;

endmodule
`default_nettype wire
